midi_note_parser: RTL and testbench
===================================

MIDI_NOTE_PARSER -- requirements
Module: midi_note_parser

Interface
REQ-001 Parameter MIDI_CHANNEL, default 4'd0: the MIDI channel (0-15) that is accepted.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 rxByte  input  8  received MIDI byte from the UART.
REQ-005 rxValid  input  1  one-cycle strobe; rxByte is valid in this cycle.
REQ-006 midiNoteNumber  output  8  current note; bit 7 is always 0.
REQ-007 noteVelocity  output  7  velocity of the current note.
REQ-008 noteGate  output  1  level; high while a note is held.
REQ-009 noteEvent  output  1  one-cycle strobe on every change of noteGate or midiNoteNumber.

Function
REQ-010 rxByte is sampled only in cycles where rxValid=1; bytes in other cycles SHALL have no effect.
REQ-011 Byte classes: 8'h80-8'hEF is channel status; 8'hF0-8'hF7 is system common; 8'hF8-8'hFF is realtime; 8'h00-8'h7F is data.
REQ-012 FSM states: IDLE (no running status), DATA1 (expecting first data byte), DATA2 (expecting second data byte).
REQ-013 Running status (type nibble, channel match flag, data count 1 or 2) SHALL be latched on every channel status byte.
REQ-014 Data count SHALL be 2 for 8x/9x/Ax/Bx/Ex and 1 for Cx/Dx.
REQ-015 A channel status byte in any state SHALL go to DATA1.
REQ-016 A system common byte in any state SHALL clear running status and go to IDLE.
REQ-017 A realtime byte SHALL be ignored, leaving state and the first data byte unchanged.
REQ-018 A data byte in IDLE SHALL be discarded.
REQ-019 A data byte in DATA1 SHALL be latched as key; go to DATA2 if count=2, else back to DATA1.
REQ-020 A data byte in DATA2 SHALL complete the message and return to DATA1 (running status).
REQ-021 Completed 9x with velocity!=0 on a matching channel: on the same edge, midiNoteNumber=key, noteVelocity=vel, noteGate=1, noteEvent=1 (last-note priority).
REQ-022 Completed 8x, or 9x with velocity=0, on a matching channel with key==midiNoteNumber and noteGate=1: noteGate=0 and noteEvent=1; midiNoteNumber and noteVelocity are held.
REQ-023 Note-off for a non-current key SHALL be ignored; noteEvent stays 0.
REQ-024 Completed Bx on a matching channel with first data byte 8'h7B (all notes off): noteGate=0; noteEvent=1 only if noteGate was 1.
REQ-025 All other messages, and messages on a non-matching channel, SHALL be consumed with no output change.
REQ-026 noteEvent SHALL be high for exactly one cycle, in the cycle after the completing rxValid edge.
REQ-027 A status byte arriving in DATA2 SHALL abandon the partial message; no output change.
REQ-028 Note-on for the key already sounding SHALL update noteVelocity and pulse noteEvent.

Reset
REQ-029 With reset_n=0 at a rising edge: state=IDLE, running status cleared, midiNoteNumber=0, noteVelocity=0, noteGate=0, noteEvent=0.
REQ-030 Reset SHALL take priority over a simultaneous rxValid; reset mid-message discards the message.

Configuration
REQ-031 With macro MIDI_NOTE_PARSER_OMNI_EN defined, every channel SHALL match and MIDI_CHANNEL SHALL be ignored.
REQ-032 Without MIDI_NOTE_PARSER_OMNI_EN, the channel matches only when status[3:0]==MIDI_CHANNEL.

Verification
REQ-033 Reset, then bytes 90 3C 64 -> midiNoteNumber=8'h3C, noteVelocity=100, noteGate=1, a single noteEvent pulse.
REQ-034 Running status: 90 3C 64 40 50 -> note 8'h40, velocity 80, gate=1; then 3C 00 -> gate stays 1, no noteEvent; then 40 00 -> gate=0, one noteEvent.
REQ-035 Realtime interleave: 90 F8 3C FE 64 -> same result as 90 3C 64; F0 3C 64 -> no change.
REQ-036 Channel filter with MIDI_CHANNEL=1, macro off: 90 3C 64 -> no change; 91 3C 64 -> gate=1; with macro on, 90 3C 64 -> gate=1.
REQ-037 Skip and CC: C0 05 90 3C 64 -> gate=1 note 3C; B0 7B 00 -> gate=0, one noteEvent; D0 3C -> no change.
REQ-038 Abandon and reset: 90 3C 80 3C 00 -> no gate; 90 3C with reset_n low before the velocity byte, then 64 -> discarded, all outputs 0.

Source files
------------

// File: rtl/midi_note_parser_if.sv
// Byte-in / note-out bundle for midi_note_parser; the slave modport is the parser's view.
interface midi_note_parser_if;
  logic [7:0] rxByte;
  logic       rxValid;
  logic [7:0] midiNoteNumber;
  logic [6:0] noteVelocity;
  logic       noteGate;
  logic       noteEvent;

  modport master (
    output rxByte, rxValid,
    input  midiNoteNumber, noteVelocity, noteGate, noteEvent
  );

  modport slave (
    input  rxByte, rxValid,
    output midiNoteNumber, noteVelocity, noteGate, noteEvent
  );
endinterface

// File: rtl/midi_note_parser.sv
// MIDI byte-stream parser producing a monophonic last-note-priority gate/note/velocity.
// Define MIDI_NOTE_PARSER_OMNI_EN to accept every channel instead of only MIDI_CHANNEL.
module midi_note_parser #(
  parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
  input logic               clk,
  input logic               reset_n,
  midi_note_parser_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DATA1, DATA2} state_t;

  state_t     state_q, state_d;
  logic [3:0] type_q, type_d;
  logic       match_q, match_d;
  logic       two_q, two_d;
  logic [6:0] key_q, key_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       gate_q, gate_d;
  logic       event_q, event_d;

  logic [7:0] rx_byte;
  logic       ch_match;
  logic       off_hit;

  assign rx_byte = bus.rxByte;

`ifdef MIDI_NOTE_PARSER_OMNI_EN
  assign ch_match = 1'b1;
`else
  assign ch_match = (rx_byte[3:0] == MIDI_CHANNEL);
`endif

  // A note-off only matters when it names the note that is currently sounding.
  assign off_hit = (key_q == note_q) && gate_q;

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    match_d = match_q;
    two_d   = two_q;
    key_d   = key_q;
    note_d  = note_q;
    vel_d   = vel_q;
    gate_d  = gate_q;
    event_d = 1'b0;

    if (bus.rxValid && (rx_byte[7:3] != 5'b11111)) begin
      if (rx_byte[7:4] == 4'hF) begin
        state_d = IDLE;
        type_d  = 4'h0;
        match_d = 1'b0;
        two_d   = 1'b0;
      end else if (rx_byte[7]) begin
        state_d = DATA1;
        type_d  = rx_byte[7:4];
        match_d = ch_match;
        two_d   = (rx_byte[7:4] != 4'hC) && (rx_byte[7:4] != 4'hD);
      end else begin
        case (state_q)
          DATA1: begin
            key_d   = rx_byte[6:0];
            state_d = two_q ? DATA2 : DATA1;
          end
          DATA2: begin
            state_d = DATA1;
            if (match_q) begin
              case (type_q)
                4'h9: begin
                  if (rx_byte[6:0] != 7'd0) begin
                    note_d  = key_q;
                    vel_d   = rx_byte[6:0];
                    gate_d  = 1'b1;
                    event_d = 1'b1;
                  end else if (off_hit) begin
                    gate_d  = 1'b0;
                    event_d = 1'b1;
                  end
                end
                4'h8: begin
                  if (off_hit) begin
                    gate_d  = 1'b0;
                    event_d = 1'b1;
                  end
                end
                4'hB: begin
                  if (key_q == 7'h7B) begin
                    gate_d  = 1'b0;
                    event_d = gate_q;
                  end
                end
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      type_q  <= 4'h0;
      match_q <= 1'b0;
      two_q   <= 1'b0;
      key_q   <= 7'd0;
      note_q  <= 7'd0;
      vel_q   <= 7'd0;
      gate_q  <= 1'b0;
      event_q <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      match_q <= match_d;
      two_q   <= two_d;
      key_q   <= key_d;
      note_q  <= note_d;
      vel_q   <= vel_d;
      gate_q  <= gate_d;
      event_q <= event_d;
    end
  end

  assign bus.midiNoteNumber = {1'b0, note_q};
  assign bus.noteVelocity   = vel_q;
  assign bus.noteGate       = gate_q;
  assign bus.noteEvent      = event_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// Self-checking bench for midi_note_parser: a message-level reference model checked every
// cycle, plus literal expectations for the directed MIDI sequences.
module tb_midi_note_parser;

  localparam int CHANNEL = 1;

  logic clk = 1'b0;
  logic reset_n;

  midi_note_parser_if bus ();

  midi_note_parser #(.MIDI_CHANNEL(4'd1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int ev_count     = 0;
  bit check_en     = 1'b0;

  logic [7:0] stim_q[$];

  // Reference model: holds the last status byte and the data bytes collected for it.
  bit         m_has_status;
  int         m_status;
  int         m_data[$];
  logic [7:0] exp_note;
  logic [6:0] exp_vel;
  logic       exp_gate;
  logic       exp_event;

  task automatic modelReset();
    m_has_status = 1'b0;
    m_status     = 0;
    m_data.delete();
    exp_note     = 8'd0;
    exp_vel      = 7'd0;
    exp_gate     = 1'b0;
    exp_event    = 1'b0;
  endtask

  task automatic modelApply(input int st, input int d0, input int d1);
    int  kind;
    bit  chan_ok;
    kind = st / 16;
`ifdef MIDI_NOTE_PARSER_OMNI_EN
    chan_ok = 1'b1;
`else
    chan_ok = ((st % 16) == CHANNEL);
`endif
    if (!chan_ok) return;
    if (kind == 9 && d1 != 0) begin
      exp_note  = 8'(d0);
      exp_vel   = 7'(d1);
      exp_gate  = 1'b1;
      exp_event = 1'b1;
    end else if ((kind == 8 || kind == 9) && exp_gate && (d0 == int'(exp_note))) begin
      exp_gate  = 1'b0;
      exp_event = 1'b1;
    end else if (kind == 11 && d0 == 123) begin
      exp_event = exp_gate;
      exp_gate  = 1'b0;
    end
  endtask

  task automatic modelByte(input int b);
    int need;
    exp_event = 1'b0;
    if (b >= 248) return;
    if (b >= 240) begin
      m_has_status = 1'b0;
      m_data.delete();
      return;
    end
    if (b >= 128) begin
      m_has_status = 1'b1;
      m_status     = b;
      m_data.delete();
      return;
    end
    if (!m_has_status) return;
    m_data.push_back(b);
    need = ((m_status / 16) == 12 || (m_status / 16) == 13) ? 1 : 2;
    if (m_data.size() == need) begin
      modelApply(m_status, m_data[0], (need == 2) ? m_data[1] : 0);
      m_data.delete();
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n)          modelReset();
    else if (bus.rxValid)  modelByte(int'(bus.rxByte));
    else                   exp_event = 1'b0;
  end

  always begin
    @(posedge clk);
    #2;
    if (bus.noteEvent === 1'b1) ev_count++;
  end

  task automatic compareOne(input string name, input logic [7:0] act, input logic [7:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      compareOne("model_note",  bus.midiNoteNumber,        exp_note);
      compareOne("model_vel",   {1'b0, bus.noteVelocity},  {1'b0, exp_vel});
      compareOne("model_gate",  {7'd0, bus.noteGate},      {7'd0, exp_gate});
      compareOne("model_event", {7'd0, bus.noteEvent},     {7'd0, exp_event});
    end
  end

  // One valid byte, then an idle cycle carrying a junk byte that must be ignored.
  task automatic applyStimulus(input logic [7:0] b);
    bus.rxByte  = b;
    bus.rxValid = 1'b1;
    @(negedge clk);
    bus.rxValid = 1'b0;
    bus.rxByte  = 8'hC1;
    @(negedge clk);
  endtask

  task automatic sendQueue();
    foreach (stim_q[i]) applyStimulus(stim_q[i]);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic doReset(input logic with_valid, input logic [7:0] b);
    bus.rxByte  = b;
    bus.rxValid = with_valid;
    reset_n     = 1'b0;
    @(negedge clk);
    reset_n     = 1'b1;
    bus.rxValid = 1'b0;
    @(negedge clk);
    ev_count = 0;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] note, input logic [6:0] vel,
                             input logic gate, input int events);
    compareOne({name, "_note"}, bus.midiNoteNumber, note);
    compareOne({name, "_vel"}, {1'b0, bus.noteVelocity}, {1'b0, vel});
    compareOne({name, "_gate"}, {7'd0, bus.noteGate}, {7'd0, gate});
    tests_run++;
    if (ev_count != events) begin
      tests_failed++;
      $display("[TB] FAIL %s_events: got %0d pulses, expected %0d", name, ev_count, events);
    end
    ev_count = 0;
  endtask

  initial begin
    bus.rxByte  = 8'h00;
    bus.rxValid = 1'b0;
    reset_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    doReset(1'b0, 8'h00);
    check_en = 1'b1;
    checkOutput("reset", 8'h00, 7'd0, 1'b0, 0);

    stim_q = {8'h91, 8'h3C, 8'h64};
    sendQueue();
    checkOutput("note_on", 8'h3C, 7'd100, 1'b1, 1);

    doReset(1'b0, 8'h00);
    stim_q = {8'h91, 8'h3C, 8'h64, 8'h40, 8'h50};
    sendQueue();
    checkOutput("running_on", 8'h40, 7'd80, 1'b1, 2);
    stim_q = {8'h3C, 8'h00};
    sendQueue();
    checkOutput("off_other", 8'h40, 7'd80, 1'b1, 0);
    stim_q = {8'h40, 8'h00};
    sendQueue();
    checkOutput("off_current", 8'h40, 7'd80, 1'b0, 1);

    doReset(1'b0, 8'h00);
    stim_q = {8'h91, 8'hF8, 8'h3C, 8'hFE, 8'h64};
    sendQueue();
    checkOutput("realtime", 8'h3C, 7'd100, 1'b1, 1);
    stim_q = {8'hF0, 8'h3C, 8'h64};
    sendQueue();
    checkOutput("syscommon", 8'h3C, 7'd100, 1'b1, 0);

    doReset(1'b0, 8'h00);
    stim_q = {8'h90, 8'h3C, 8'h64};
    sendQueue();
`ifdef MIDI_NOTE_PARSER_OMNI_EN
    checkOutput("other_chan", 8'h3C, 7'd100, 1'b1, 1);
`else
    checkOutput("other_chan", 8'h00, 7'd0, 1'b0, 0);
`endif
    stim_q = {8'h91, 8'h3C, 8'h64};
    sendQueue();
    checkOutput("match_chan", 8'h3C, 7'd100, 1'b1, 1);

    doReset(1'b0, 8'h00);
    stim_q = {8'hC1, 8'h05, 8'h91, 8'h3C, 8'h64};
    sendQueue();
    checkOutput("skip_pc", 8'h3C, 7'd100, 1'b1, 1);
    stim_q = {8'hB1, 8'h7B, 8'h00};
    sendQueue();
    checkOutput("all_off", 8'h3C, 7'd100, 1'b0, 1);
    stim_q = {8'hD1, 8'h3C};
    sendQueue();
    checkOutput("chan_press", 8'h3C, 7'd100, 1'b0, 0);
    stim_q = {8'hB1, 8'h7B, 8'h00};
    sendQueue();
    checkOutput("all_off_idle", 8'h3C, 7'd100, 1'b0, 0);

    doReset(1'b0, 8'h00);
    stim_q = {8'h91, 8'h3C, 8'h81, 8'h3C, 8'h00};
    sendQueue();
    checkOutput("abandon", 8'h00, 7'd0, 1'b0, 0);
    stim_q = {8'h91, 8'h3C};
    sendQueue();
    doReset(1'b1, 8'h64);
    stim_q = {8'h64};
    sendQueue();
    checkOutput("reset_mid", 8'h00, 7'd0, 1'b0, 0);

    doReset(1'b0, 8'h00);
    stim_q = {8'h91, 8'h3C, 8'h64, 8'h3C, 8'h20};
    sendQueue();
    checkOutput("same_key", 8'h3C, 7'h20, 1'b1, 2);
    stim_q = {8'h81, 8'h50, 8'h00};
    sendQueue();
    checkOutput("off_non_current", 8'h3C, 7'h20, 1'b1, 0);
    stim_q = {8'h91, 8'h45, 8'h30, 8'h81, 8'h3C, 8'h00};
    sendQueue();
    checkOutput("last_priority", 8'h45, 7'h30, 1'b1, 1);
    stim_q = {8'h91, 8'h45, 8'h00};
    sendQueue();
    checkOutput("on_vel0_off", 8'h45, 7'h30, 1'b0, 1);

    check_en = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
